// File: rtl/sample_framer_pkg.sv
// Shared defaults and state encoding for the sample framer.
// Imported by the interface, the framer and its buffer.
package rf_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_DEPTH = 16;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        DRAIN
    } framer_state_t;

endpackage

// File: rtl/sample_framer_if.sv
// Upstream handshake, replay and status signals of the sample framer.
// The master modport is the stimulus side; the slave modport is the framer itself.
interface sample_framer_if
    import rf_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);

    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_sof;
    logic             in_eof;
    logic             in_ready;
    logic [WIDTH-1:0] data_out;
    logic             go;
    logic             finish;
    logic             frame_err;
    logic             busy;

    modport master (
        output in_data, in_valid, in_sof, in_eof,
        input  in_ready, data_out, go, finish, frame_err, busy
    );

    modport slave (
        input  in_data, in_valid, in_sof, in_eof,
        output in_ready, data_out, go, finish, frame_err, busy
    );

endinterface

// File: rtl/sample_framer_buffer.sv
// Frame storage: DEPTH x WIDTH, one synchronous write port, one combinational read port.
// Contents are deliberately left unreset.
module frame_buffer
    import rf_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                     clock,
    input  logic                     i_wrEn,
    input  logic [$clog2(DEPTH)-1:0] i_wrAddr,
    input  logic [WIDTH-1:0]         i_wrData,
    input  logic [$clog2(DEPTH)-1:0] i_rdAddr,
    output logic [WIDTH-1:0]         o_rdData
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clock) begin
        if (i_wrEn) begin
            r_mem[i_wrAddr] <= i_wrData;
        end
    end

    assign o_rdData = r_mem[i_rdAddr];

endmodule

// File: rtl/sample_framer.sv
// Store-and-forward framer: collects a gappy upstream frame, then replays it
// contiguously with go on the first sample and finish on the last.
module sample_framer
    import rf_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input logic            clock,
    input logic            reset,
    sample_framer_if.slave bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    framer_state_t   r_state, w_nextState;
    logic [CW-1:0]   r_count, w_nextCount;
    logic [AW-1:0]   r_rdIdx, w_nextRdIdx;
    logic            r_frameErr, w_frameErr;
    logic            r_discard, w_nextDiscard;
    logic            w_accept;
    logic            w_lastRead;
    logic            w_draining;
    logic            w_wrEn;
    logic [AW-1:0]   w_wrAddr;
    logic [WIDTH-1:0] w_rdData;

    assign w_accept   = bus.in_valid && (r_state != DRAIN);
    assign w_lastRead = ({1'b0, r_rdIdx} == (r_count - CW'(1)));

    // r_discard swallows the tail of an overflowed frame so it reports only one fault
    always_comb begin
        w_nextState   = r_state;
        w_nextCount   = r_count;
        w_nextRdIdx   = r_rdIdx;
        w_frameErr    = 1'b0;
        w_nextDiscard = r_discard;
        w_wrEn        = 1'b0;
        w_wrAddr      = '0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (bus.in_sof) begin
                        w_nextDiscard = 1'b0;
                        if (bus.in_eof) begin
                            w_frameErr = 1'b1;
                        end else begin
                            w_wrEn      = 1'b1;
                            w_nextCount = CW'(1);
                            w_nextState = COLLECT;
                        end
                    end else if (bus.in_eof) begin
                        w_frameErr    = !r_discard;
                        w_nextDiscard = 1'b0;
                    end
                end
            end
            COLLECT: begin
                if (w_accept) begin
                    if (bus.in_sof) begin
                        w_frameErr = 1'b1;
                        if (bus.in_eof) begin
                            w_nextCount = '0;
                            w_nextState = IDLE;
                        end else begin
                            w_wrEn      = 1'b1;
                            w_nextCount = CW'(1);
                        end
                    end else if (r_count == CW'(DEPTH)) begin
                        w_frameErr    = 1'b1;
                        w_nextCount   = '0;
                        w_nextState   = IDLE;
                        w_nextDiscard = !bus.in_eof;
                    end else begin
                        w_wrEn      = 1'b1;
                        w_wrAddr    = r_count[AW-1:0];
                        w_nextCount = r_count + CW'(1);
                        if (bus.in_eof) begin
                            w_nextRdIdx = '0;
                            w_nextState = DRAIN;
                        end
                    end
                end
            end
            DRAIN: begin
                if (w_lastRead) begin
                    w_nextCount = '0;
                    w_nextRdIdx = '0;
                    w_nextState = IDLE;
                end else begin
                    w_nextRdIdx = r_rdIdx + AW'(1);
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= IDLE;
            r_count    <= '0;
            r_rdIdx    <= '0;
            r_frameErr <= 1'b0;
            r_discard  <= 1'b0;
        end else begin
            r_state    <= w_nextState;
            r_count    <= w_nextCount;
            r_rdIdx    <= w_nextRdIdx;
            r_frameErr <= w_frameErr;
            r_discard  <= w_nextDiscard;
        end
    end

    frame_buffer #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_buffer (
        .clock    (clock),
        .i_wrEn   (w_wrEn),
        .i_wrAddr (w_wrAddr),
        .i_wrData (bus.in_data),
        .i_rdAddr (r_rdIdx),
        .o_rdData (w_rdData)
    );

    // Outputs are gated by reset so nothing leaks while reset is held
    assign w_draining    = (r_state == DRAIN) && !reset;
    assign bus.in_ready  = (r_state != DRAIN);
    assign bus.data_out  = w_draining ? w_rdData : '0;
    assign bus.go        = w_draining && (r_rdIdx == '0);
    assign bus.finish    = w_draining && w_lastRead;
    assign bus.frame_err = r_frameErr && !reset;
    assign bus.busy      = (r_state != IDLE) && !reset;

endmodule

// File: doc/sample_framer.md
SAMPLE_FRAMER -- requirements
Module: sample_framer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, sample width in bits.
REQ-002 SHALL have parameter DEPTH, default 16, maximum samples per frame.
REQ-003 SHALL have one clock and a synchronous, active-high reset, with ports named as follows:
- clock  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have the following upstream ports:
- in_data  in  WIDTH  sample.
- in_valid  in  1  sample present.
- in_sof  in  1  first sample of frame, qualified by in_valid.
- in_eof  in  1  last sample of frame, qualified by in_valid.
- in_ready  out  1  beat accepted when in_valid and in_ready are both high.
REQ-005 SHALL have the following downstream ports (range-finder side):
- data_out  out  WIDTH  replayed sample.
- go  out  1  high with first sample.
- finish  out  1  high with last sample.
REQ-006 SHALL have the following status ports:
- frame_err  out  1  one-cycle pulse on a protocol fault.
- busy  out  1  high while state is not IDLE.

Function
REQ-007 SHALL be store-and-forward: collect a whole frame from a gappy input, then replay it contiguously, one sample per cycle.
REQ-008 SHALL implement a state machine with states IDLE, COLLECT, DRAIN.
REQ-009 In IDLE and COLLECT, in_ready SHALL be 1; in DRAIN, in_ready SHALL be 0.
REQ-010 In IDLE, an accepted beat with in_sof=1 and in_eof=0 SHALL write the sample at index 0, set count=1 and go to COLLECT.
REQ-011 In IDLE, an accepted beat without in_sof SHALL be discarded; if it has in_eof=1, frame_err SHALL pulse the next cycle.
REQ-012 In COLLECT, an accepted beat with in_sof=0 SHALL write at index count and increment count.
- If in_eof=1 on that beat, the state SHALL become DRAIN.
REQ-013 In COLLECT, an accepted beat with in_sof=1 SHALL restart the frame:
- the previous partial frame is dropped and frame_err pulses;
- the new sample goes to index 0 and count becomes 1;
- if in_eof=1 on the same beat, REQ-014 applies.
REQ-014 A beat with in_sof=1 and in_eof=1 (length-1 frame) SHALL be dropped, pulse frame_err and return to IDLE.
REQ-015 An accepted beat arriving when count=DEPTH without in_eof SHALL cause overflow:
- frame dropped, frame_err pulses, state returns to IDLE;
- following beats are discarded until the next in_sof.
REQ-016 A frame of exactly DEPTH samples ending with in_eof SHALL be valid.
REQ-017 If eof is accepted on cycle t, go SHALL be high on cycle t+1 with data_out = sample 0.
REQ-018 In DRAIN, data_out SHALL present samples 0..len-1 on consecutive cycles with no gaps.
- finish SHALL be high only on the cycle carrying sample len-1.
- go and finish SHALL never be high in the same cycle.
REQ-019 After the finish cycle, the state SHALL be IDLE on the next cycle, with in_ready=1.
REQ-020 Outside DRAIN, data_out, go and finish SHALL be 0.
REQ-021 count SHALL be $clog2(DEPTH)+1 bits wide, with no wrap-around; overflow is handled only by REQ-015.
REQ-022 frame_err SHALL be registered, exactly one cycle per fault, and SHALL not stall the state machine.

Reset
REQ-023 While reset=1 at a rising edge, the state SHALL become IDLE and count SHALL become 0.
REQ-024 During reset, data_out, go, finish, frame_err and busy SHALL all be 0.
REQ-025 Reset asserted mid-COLLECT or mid-DRAIN SHALL abandon the frame with no finish and no frame_err.
REQ-026 Buffer contents SHALL need no reset.

Structure
REQ-027 A shared package rf_pkg SHALL hold the WIDTH and DEPTH defaults and the framer_state_t enum (IDLE, COLLECT, DRAIN).
REQ-028 Storage SHALL be one sub-module, frame_buffer: DEPTH x WIDTH, one synchronous write port and one combinational read port.
REQ-029 Control, count and read index SHALL reside in sample_framer.

Verification
REQ-030 Scenario: frame 5,9,2,7 with in_valid gaps of 0-3 cycles between beats, sof on 5 and eof on 7.
- Required: go with 5 one cycle after eof; then 9, 2, 7 contiguous; finish with 7; in_ready=0 for 4 cycles.
REQ-031 Scenario: sof=1 and eof=1 on the same beat, data 0x33.
- Required: frame_err pulse; no go; state IDLE; in_ready=1.
REQ-032 Scenario: 17 beats starting with sof, no eof.
- Required: frame_err on the 17th beat; no go; a following valid frame 1,2 replays correctly.
REQ-033 Scenario: 16-beat frame 0..15 with eof on 15.
- Required: 16 contiguous outputs, go on 0, finish on 15.
REQ-034 Scenario: sof, 3 beats, then a new sof, 1, eof with 4.
- Required: one frame_err pulse; replay 1,4 with go and finish.
REQ-035 Scenario: reset asserted in the 2nd DRAIN cycle of a 4-sample frame.
- Required: go, finish and data_out are 0 the next cycle; busy=0; a subsequent frame works.
